// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the five-stage pipeline: RAW hazard stalls, bus-wait freeze, branch flush.
// Optional bus watchdog is compiled in with `define BUS_TIMEOUT_EN (limit set by TIMEOUT).
module pipeline_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid,
    input  logic [4:0]  exe_rs1_address,
    input  logic [4:0]  exe_rs2_address,
    input  logic        exe_uses_rs1,
    input  logic        exe_uses_rs2,
    input  logic [4:0]  mem_rd_addr,
    input  logic [4:0]  wb_rd_addr,
    input  logic        mem_rd_we,
    input  logic        wb_rd_we,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        decode_invalidate,
    output logic        exe_invalidate,
    output logic        mem_invalidate,
    output logic        pc_redirect,
    output logic        stall_active,
    output logic [15:0] stall_cycles,
    output logic        bus_error
);

    // state     | meaning
    // RUN       | normal issue
    // MEM_WAIT  | memory stage waiting on the data bus
    // FLUSH     | decode refilling after a redirect
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic       freeze, hazard, rs1_hit, rs2_hit, timeout, any_en_low;

    assign freeze = mem_req && !mem_ack;

    assign rs1_hit = exe_uses_rs1 && (exe_rs1_address != 5'd0) &&
                     ((mem_rd_we && exe_rs1_address == mem_rd_addr) ||
                      (wb_rd_we  && exe_rs1_address == wb_rd_addr));
    assign rs2_hit = exe_uses_rs2 && (exe_rs2_address != 5'd0) &&
                     ((mem_rd_we && exe_rs2_address == mem_rd_addr) ||
                      (wb_rd_we  && exe_rs2_address == wb_rd_addr));
    assign hazard  = exe_valid && (rs1_hit || rs2_hit);

`ifdef BUS_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    // to_cnt holds the number of wait cycles already spent; the freeze cycle in RUN/FLUSH is the first.
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == ST_MEM_WAIT) && freeze && (to_cnt >= TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (freeze && !timeout)
            to_cnt <= (state == ST_MEM_WAIT) ? to_cnt + TO_W'(1) : TO_W'(1);
        else
            to_cnt <= '0;
    end

    assign mem_invalidate = rst ? 1'b1 : timeout;
    assign bus_error      = !rst && timeout;
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT);

    assign timeout        = 1'b0;
    assign mem_invalidate = 1'b0;
    assign bus_error      = 1'b0;
`endif

    always_comb begin
        state_nxt         = state;
        flush_cnt_nxt     = flush_cnt;
        fetch_en          = 1'b1;
        decode_en         = 1'b1;
        exe_en            = 1'b1;
        mem_en            = 1'b1;
        wb_en             = 1'b1;
        decode_invalidate = 1'b0;
        exe_invalidate    = 1'b0;
        pc_redirect       = 1'b0;
        stall_active      = 1'b0;
        if (rst) begin
            {fetch_en, decode_en, exe_en, mem_en, wb_en} = 5'b0;
            decode_invalidate = 1'b1;
            exe_invalidate    = 1'b1;
        end else if (timeout) begin
            state_nxt     = ST_RUN;
            flush_cnt_nxt = 4'd0;
        end else if (freeze) begin
            {fetch_en, decode_en, exe_en, mem_en, wb_en} = 5'b0;
            state_nxt = ST_MEM_WAIT;
        end else begin
            if (state == ST_FLUSH)
                decode_invalidate = 1'b1;
            if (branch_taken) begin
                pc_redirect       = 1'b1;
                decode_invalidate = 1'b1;
                exe_invalidate    = 1'b1;
                flush_cnt_nxt     = FLUSH_RELOAD;
                state_nxt         = (FLUSH_RELOAD == 4'd0) ? ST_RUN : ST_FLUSH;
            end else begin
                if (hazard) begin
                    fetch_en       = 1'b0;
                    decode_en      = 1'b0;
                    exe_en         = 1'b0;
                    exe_invalidate = 1'b1;
                    stall_active   = 1'b1;
                end
                case (state)
                    ST_FLUSH: begin
                        flush_cnt_nxt = (flush_cnt == 4'd0) ? 4'd0 : flush_cnt - 4'd1;
                        state_nxt     = (flush_cnt <= 4'd1) ? ST_RUN : ST_FLUSH;
                    end
                    // A flush interrupted by a bus wait picks up where it stopped.
                    ST_MEM_WAIT: state_nxt = (flush_cnt != 4'd0) ? ST_FLUSH : ST_RUN;
                    default:     state_nxt = ST_RUN;
                endcase
            end
        end
    end

    assign any_en_low = !(fetch_en && decode_en && exe_en && mem_en && wb_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            flush_cnt    <= 4'd0;
            stall_cycles <= 16'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (any_en_low && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a cycle-level behavioural model of the sequencer rules.
module tb_pipeline_sequencer;

    localparam int FC = 2;
    localparam int TO = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       exe_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses1;
        logic       uses2;
        logic [4:0] mem_rd;
        logic [4:0] wb_rd;
        logic       mem_we;
        logic       wb_we;
        logic       branch;
        logic       mem_req;
        logic       mem_ack;
    } stim_t;

    typedef struct {
        logic [26:0] v;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_valid = 1'b0, exe_uses_rs1 = 1'b0, exe_uses_rs2 = 1'b0;
    logic [4:0]  exe_rs1_address = '0, exe_rs2_address = '0, mem_rd_addr = '0, wb_rd_addr = '0;
    logic        mem_rd_we = 1'b0, wb_rd_we = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic        fetch_en, decode_en, exe_en, mem_en, wb_en;
    logic        decode_invalidate, exe_invalidate, mem_invalidate, pc_redirect, stall_active, bus_error;
    logic [15:0] stall_cycles;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Model state: cycles of flush still owed to decode, whether the last cycle was a bus
    // wait, how many consecutive wait cycles so far, and the stall tally.
    int m_flush   = 0;
    bit m_waiting = 1'b0;
    int m_wait    = 0;
    int m_stalls  = 0;

    pipeline_sequencer #(.FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_rs1_address(exe_rs1_address), .exe_rs2_address(exe_rs2_address),
        .exe_uses_rs1(exe_uses_rs1), .exe_uses_rs2(exe_uses_rs2),
        .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr), .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .fetch_en(fetch_en), .decode_en(decode_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .decode_invalidate(decode_invalidate), .exe_invalidate(exe_invalidate),
        .mem_invalidate(mem_invalidate), .pc_redirect(pc_redirect), .stall_active(stall_active),
        .stall_cycles(stall_cycles), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic bit reads_pending(input logic [4:0] rs, input logic used, input stim_t s);
        return used && rs != 5'd0 && ((s.mem_we && rs == s.mem_rd) || (s.wb_we && rs == s.wb_rd));
    endfunction

    task automatic model_cycle(input stim_t s, output logic [26:0] v);
        logic [4:0] en;
        logic       di, xi, mi, pr, sa, be;
        bit         frozen, haz, in_flush, tmo;
        logic [15:0] shown;
        if (s.rst) begin
            m_flush = 0; m_waiting = 1'b0; m_wait = 0; m_stalls = 0;
            v = {5'b00000, 1'b1, 1'b1, 1'(TO_EN), 1'b0, 1'b0, 1'b0, 16'h0000};
            return;
        end
        shown    = 16'(m_stalls);
        frozen   = s.mem_req && !s.mem_ack;
        haz      = s.exe_valid && (reads_pending(s.rs1, s.uses1, s) || reads_pending(s.rs2, s.uses2, s));
        in_flush = (m_flush > 0) && !m_waiting;
        tmo      = TO_EN && frozen && m_waiting && (m_wait + 1 >= TO);
        en = 5'b11111; di = 0; xi = 0; mi = 0; pr = 0; sa = 0; be = 0;
        if (tmo) begin
            mi = 1; be = 1;
            m_waiting = 1'b0; m_wait = 0; m_flush = 0;
        end else if (frozen) begin
            en = 5'b00000;
            m_waiting = 1'b1; m_wait++;
        end else begin
            if (in_flush) di = 1;
            if (s.branch) begin
                pr = 1; di = 1; xi = 1;
                m_flush = FC - 1;
            end else begin
                if (haz) begin
                    en = 5'b00011; xi = 1; sa = 1;
                end
                if (in_flush) m_flush--;
            end
            m_waiting = 1'b0; m_wait = 0;
        end
        if (en != 5'b11111 && m_stalls < 65535) m_stalls++;
        v = {en, di, xi, mi, pr, sa, be, shown};
    endtask

    task automatic step(input stim_t s, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst;
        exe_valid = s.exe_valid;
        exe_rs1_address = s.rs1;  exe_rs2_address = s.rs2;
        exe_uses_rs1 = s.uses1;   exe_uses_rs2 = s.uses2;
        mem_rd_addr = s.mem_rd;   wb_rd_addr = s.wb_rd;
        mem_rd_we = s.mem_we;     wb_rd_we = s.wb_we;
        branch_taken = s.branch;  mem_req = s.mem_req;  mem_ack = s.mem_ack;
        model_cycle(s, e.v);
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [26:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {fetch_en, decode_en, exe_en, mem_en, wb_en, decode_invalidate, exe_invalidate,
                       mem_invalidate, pc_redirect, stall_active, bus_error, stall_cycles};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s @%0t: actual=%h required=%h (en,dinv,xinv,minv,redir,stall,berr,count)",
                             e.name, $time, act, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        stim_t s;
        bit    req_pending;

        s = '0; s.rst = 1'b1;
        repeat (3) step(s, "reset_hold");
        s = '0;
        step(s, "post_reset");

        s = '0; s.exe_valid = 1; s.rs1 = 5; s.uses1 = 1; s.mem_rd = 5; s.mem_we = 1;
        step(s, "hazard_mem_rs1");
        s.rs1 = 0; s.mem_rd = 0;
        step(s, "hazard_r0_ignored");
        s.rs1 = 5; s.mem_rd = 5; s.exe_valid = 0;
        step(s, "hazard_bubble_ignored");
        s = '0; s.exe_valid = 1; s.rs2 = 9; s.uses2 = 1; s.wb_rd = 9; s.wb_we = 1;
        step(s, "hazard_wb_rs2");

        s.branch = 1;
        step(s, "branch_over_hazard");
        s = '0;
        step(s, "flush_cycle");
        step(s, "after_flush");

        s = '0; s.mem_req = 1; s.branch = 1;
        repeat (4) step(s, "bus_wait");
        s.mem_ack = 1;
        step(s, "bus_ack_redirect");
        s = '0;
        step(s, "bus_ack_flush");
        step(s, "bus_after");

        s = '0; s.mem_req = 1;
        repeat (9) step(s, "timeout_wait");
        s = '0;
        step(s, "timeout_exit");
        s.mem_req = 1;
        repeat (7) step(s, "ack_on_8_wait");
        s.mem_ack = 1;
        step(s, "ack_on_8");
        s = '0;
        step(s, "ack_on_8_after");

        s = '0; s.branch = 1;
        step(s, "flush_then_wait_branch");
        s = '0; s.mem_req = 1;
        repeat (2) step(s, "flush_frozen");
        s.mem_ack = 1;
        step(s, "flush_wait_ack");
        s = '0;
        step(s, "flush_resumed");
        step(s, "flush_resume_done");

        s = '0; s.mem_req = 1;
        repeat (3) step(s, "pre_reset_wait");
        s.rst = 1;
        repeat (2) step(s, "reset_mid_wait");
        s = '0;
        step(s, "post_reset_wait");

        req_pending = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            s = '0;
            s.rst       = ($urandom_range(0, 499) == 0);
            s.exe_valid = ($urandom_range(0, 3) != 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.uses1     = 1'($urandom_range(0, 1));
            s.uses2     = 1'($urandom_range(0, 1));
            s.mem_rd    = 5'($urandom_range(0, 3));
            s.wb_rd     = 5'($urandom_range(0, 3));
            s.mem_we    = 1'($urandom_range(0, 1));
            s.wb_we     = 1'($urandom_range(0, 1));
            s.branch    = ($urandom_range(0, 7) == 0);
            if (!req_pending) req_pending = ($urandom_range(0, 3) == 0);
            s.mem_req   = req_pending;
            s.mem_ack   = req_pending && ($urandom_range(0, 4) == 0);
            if (s.mem_ack || s.rst) req_pending = 1'b0;
            step(s, "random");
        end

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending entries required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
